// File: rtl/mem_pkg.sv
// Shared memory-side defaults and store buffer entry layout.
// Used by the store buffer, its interface and its match logic.
package mem_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int AW_DEF    = 32;

  typedef struct packed {
    logic [AW_DEF-3:0] waddr;
    logic [AW_DEF-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// MEM-stage store/load port plus the data memory port of the store buffer.
// master drives the pipeline side; slave is the buffer itself.
interface store_buffer_if
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [AW-1:0] st_data;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [AW-1:0] ld_data;
  logic          stall;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [AW-1:0] mem_write_data;
  logic [AW-1:0] mem_read_data;
  logic [CW-1:0] count;
  logic          empty;

  modport master (
    output st_valid, st_addr, st_data,
    output ld_valid, ld_addr, mem_read_data,
    input  ld_data, stall, mem_write,
    input  mem_address, mem_write_data,
    input  count, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data,
    input  ld_valid, ld_addr, mem_read_data,
    output ld_data, stall, mem_write,
    output mem_address, mem_write_data,
    output count, empty
  );

endinterface

// File: rtl/store_buffer_match.sv
// Store-to-load forwarding search over the occupied buffer entries.
// Youngest matching entry wins.
module store_buffer_match
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic [AW-3:0] addr [DEPTH],
  input  logic [AW-1:0] data [DEPTH],
  input  logic [PW-1:0] head,
  input  logic [CW-1:0] count,
  input  logic [AW-1:0] ld_addr,
  output logic          hit,
  output logic [AW-1:0] hit_data
);

  logic [PW-1:0] idx;
  logic          unused_lo;

  assign unused_lo = ^ld_addr[1:0];

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count &&
          addr[idx] == ld_addr[AW-1:2]) begin
        hit      = 1'b1;
        hit_data = data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Word store buffer between MEM stage and data memory.
// Loads own the memory port; stores drain in order when it is free.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input logic          clk,
  input logic          rst_n,
  store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-3:0] addr_q [DEPTH];
  logic [AW-1:0] data_q [DEPTH];

  logic          full;
  logic          empty;
  logic          push;
  logic          drain;
  logic          hit;
  logic [AW-1:0] hit_data;
  logic          unused_lo;

  assign unused_lo = ^bus.st_addr[1:0];

  always_comb begin
    full    = count_q == CW'(DEPTH);
    empty   = count_q == '0;
    push    = bus.st_valid && !full;
    drain   = !bus.ld_valid && !empty;
    head_d  = head_q + PW'(drain);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(drain);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload is never reset; occupancy comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.st_addr[AW-1:2];
      data_q[tail_q] <= bus.st_data;
    end
  end

  store_buffer_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_match (
    .addr     (addr_q),
    .data     (data_q),
    .head     (head_q),
    .count    (count_q),
    .ld_addr  (bus.ld_addr),
    .hit      (hit),
    .hit_data (hit_data)
  );

  assign bus.stall     = bus.st_valid && full;
  assign bus.mem_write = drain;
  assign bus.count     = count_q;
  assign bus.empty     = empty;
  assign bus.ld_data   = hit ? hit_data
                             : bus.mem_read_data;

  assign bus.mem_address =
    bus.ld_valid ? bus.ld_addr :
    drain        ? {addr_q[head_q], 2'b00} :
                   '0;

  assign bus.mem_write_data =
    drain ? data_q[head_q] : '0;

endmodule
